// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: synchronises the pins, deframes 11-bit frames and tracks the
// currently held key from make/break/E0 sequences, suppressing typematic repeats.
module ps2_key_decoder #(
    parameter int unsigned TIMEOUT = 8192
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] scan_code,
    output logic       scan_ext,
    output logic       key_down,
    output logic       key_press,
    output logic [7:0] press_count,
    output logic       frame_err
);

    localparam int unsigned TmoW = $clog2(TIMEOUT + 1);

    localparam logic [1:0] StIdle   = 2'd0;
    localparam logic [1:0] StExt    = 2'd1;
    localparam logic [1:0] StBrk    = 2'd2;
    localparam logic [1:0] StExtBrk = 2'd3;

    logic [2:0]      clk_sync_q;
    logic [1:0]      data_sync_q;
    logic            fall;
    logic            data_bit;

    logic [3:0]      bit_cnt_q, bit_cnt_d;
    logic [9:0]      shift_q, shift_d;
    logic [TmoW-1:0] tmo_q, tmo_d;
    logic            byte_valid_q, byte_valid_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            frame_err_q, frame_err_d;

    logic [1:0]      state_q, state_d;
    logic [7:0]      scan_code_q, scan_code_d;
    logic            scan_ext_q, scan_ext_d;
    logic            key_down_q, key_down_d;
    logic            key_press_q, key_press_d;
    logic [7:0]      press_count_q, press_count_d;

    logic            do_make;
    logic            do_break;
    logic            ev_ext;
    logic            held_match;

    // Data goes through one flop fewer than the clock so the bit sampled alongside a
    // detected falling edge is the one present when the pin clock fell.
    assign fall     = clk_sync_q[2] & ~clk_sync_q[1];
    assign data_bit = data_sync_q[1];

    always_comb begin
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        tmo_d        = tmo_q;
        byte_valid_d = 1'b0;
        rx_byte_d    = rx_byte_q;
        frame_err_d  = 1'b0;
        if (fall) begin
            tmo_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = 4'd0;
                // shift_q: [0]=start, [8:1]=data, [9]=parity; data_bit is the stop bit
                if (!shift_q[0] && data_bit && (^shift_q[9:1])) begin
                    byte_valid_d = 1'b1;
                    rx_byte_d    = shift_q[8:1];
                end else begin
                    frame_err_d = 1'b1;
                end
            end else begin
                shift_d   = {data_bit, shift_q[9:1]};
                bit_cnt_d = bit_cnt_q + 4'd1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (tmo_q == TmoW'(TIMEOUT - 1)) begin
                bit_cnt_d   = 4'd0;
                tmo_d       = '0;
                frame_err_d = 1'b1;
            end else begin
                tmo_d = tmo_q + TmoW'(1);
            end
        end else begin
            tmo_d = '0;
        end
    end

    always_comb begin
        state_d  = state_q;
        do_make  = 1'b0;
        do_break = 1'b0;
        ev_ext   = 1'b0;
        if (frame_err_q) begin
            state_d = StIdle;
        end else if (byte_valid_q) begin
            case (state_q)
                StIdle: begin
                    if (rx_byte_q == 8'hE0) begin
                        state_d = StExt;
                    end else if (rx_byte_q == 8'hF0) begin
                        state_d = StBrk;
                    end else if (rx_byte_q != 8'h00 && rx_byte_q != 8'hFF) begin
                        do_make = 1'b1;
                    end
                end
                StExt: begin
                    if (rx_byte_q == 8'hF0) begin
                        state_d = StExtBrk;
                    end else if (rx_byte_q != 8'hE0) begin
                        do_make = 1'b1;
                        ev_ext  = 1'b1;
                        state_d = StIdle;
                    end
                end
                StBrk: begin
                    do_break = (rx_byte_q != 8'hE0) && (rx_byte_q != 8'hF0);
                    state_d  = StIdle;
                end
                default: begin
                    do_break = (rx_byte_q != 8'hE0) && (rx_byte_q != 8'hF0);
                    ev_ext   = 1'b1;
                    state_d  = StIdle;
                end
            endcase
        end
    end

    assign held_match = key_down_q && (scan_code_q == rx_byte_q) && (scan_ext_q == ev_ext);

    always_comb begin
        scan_code_d   = scan_code_q;
        scan_ext_d    = scan_ext_q;
        key_down_d    = key_down_q;
        key_press_d   = 1'b0;
        press_count_d = press_count_q;
        if (do_make && !held_match) begin
            scan_code_d   = rx_byte_q;
            scan_ext_d    = ev_ext;
            key_down_d    = 1'b1;
            key_press_d   = 1'b1;
            press_count_d = press_count_q + 8'd1;
        end
        if (do_break && held_match) begin
            scan_code_d = 8'h00;
            scan_ext_d  = 1'b0;
            key_down_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_sync_q    <= '0;
            data_sync_q   <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            tmo_q         <= '0;
            byte_valid_q  <= 1'b0;
            rx_byte_q     <= '0;
            frame_err_q   <= 1'b0;
            state_q       <= StIdle;
            scan_code_q   <= '0;
            scan_ext_q    <= 1'b0;
            key_down_q    <= 1'b0;
            key_press_q   <= 1'b0;
            press_count_q <= '0;
        end else begin
            clk_sync_q    <= {clk_sync_q[1:0], ps2_clk};
            data_sync_q   <= {data_sync_q[0], ps2_data};
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            tmo_q         <= tmo_d;
            byte_valid_q  <= byte_valid_d;
            rx_byte_q     <= rx_byte_d;
            frame_err_q   <= frame_err_d;
            state_q       <= state_d;
            scan_code_q   <= scan_code_d;
            scan_ext_q    <= scan_ext_d;
            key_down_q    <= key_down_d;
            key_press_q   <= key_press_d;
            press_count_q <= press_count_d;
        end
    end

    assign scan_code   = scan_code_q;
    assign scan_ext    = scan_ext_q;
    assign key_down    = key_down_q;
    assign key_press   = key_press_q;
    assign press_count = press_count_q;
    assign frame_err   = frame_err_q;

endmodule

// File: doc/ps2_key_decoder.md
# ps2_key_decoder

Receives raw PS/2 keyboard frames and turns them into a held-key scan code for the downstream scan-code-to-ASCII stage. It sits between the board's ps2_clk/ps2_data pins and the ASCII lookup. It synchronises the PS/2 lines, deframes 11-bit frames with parity/stop checking, and interprets E0/F0 prefixes. It outputs the currently held key, a one-cycle press pulse, and a wrapping press counter. Typematic repeats are suppressed.

## Interface
- TIMEOUT, 8192: clk cycles with no ps2_clk falling edge, while a frame is partially received, before the frame is discarded.
- clk  in  1  system clock; sole clock domain.
- clrn  in  1  reset, asynchronous, active-low.
- ps2_clk  in  1  PS/2 clock pin, asynchronous to clk.
- ps2_data  in  1  PS/2 data pin, asynchronous to clk.
- scan_code  out  8  make code of held key; 8'h00 when no key is held.
- scan_ext  out  1  held key was E0-prefixed.
- key_down  out  1  a key is currently held.
- key_press  out  1  one-cycle pulse on each new press.
- press_count  out  8  count of new presses, wraps FF->00.
- frame_err  out  1  one-cycle pulse on a parity, start or stop error, or on a timeout.

## Operation
- Sync: ps2_clk passes through a 3-flop chain and ps2_data through a 2-flop chain, aligned so that data is sampled in the same cycle the clock edge is detected.
  - Falling edge = the two oldest clock-sync flops read 1 then 0.
- Receiver: bit counter 0..10, 10-bit shift buffer.
  - Each detected falling edge: store the sampled data bit (LSB first after the start bit) and increment the counter.
  - On the 11th edge, check start==0, stop==1, and odd parity over data[7:0] plus the parity bit.
  - Pass: byte_valid pulses with the byte. Fail: frame_err pulses and the byte is dropped.
  - The counter returns to 0 in both cases.
- Timeout: a cycle counter runs while the bit counter != 0 and clears on every falling edge. On reaching TIMEOUT: bit counter <= 0, frame_err pulses.
- Decoder FSM, states IDLE, EXT, BRK, EXT_BRK, advancing only on byte_valid:
  - IDLE: E0->EXT; F0->BRK; 00/FF ignored; any other byte b: make(b,0).
  - EXT: F0->EXT_BRK; E0 stays in EXT; other b: make(b,1), ->IDLE.
  - BRK: b not E0/F0: break(b,0); E0/F0 dropped; ->IDLE.
  - EXT_BRK: b not E0/F0: break(b,1); E0/F0 dropped; ->IDLE.
  - Any frame_err forces the FSM to IDLE (prefix lost).
- make(b,e):
  - If key_down and {scan_code,scan_ext}=={b,e}: repeat, no change, no pulse.
  - Otherwise: scan_code<=b, scan_ext<=e, key_down<=1, key_press pulses, press_count+1 mod 256.
- break(b,e):
  - If key_down and the held key matches: key_down<=0, scan_code<=00, scan_ext<=0.
  - A non-matching break is ignored (the held key stays).
- A new make while another key is held replaces the held key and counts as a press.

## Timing
- Reset (clrn low, async): all outputs 0, FSM IDLE, bit/timeout counters 0, sync flops 0.
  - Reset mid-frame discards the partial frame; no frame_err.
- Cycle E = the cycle in which the stop-bit falling edge is detected, ~3 clk after the pin edge.
  - byte_valid is high in E+1.
  - scan_code/scan_ext/key_down/press_count update at the end of E+1 and are visible in E+2.
  - key_press is high exactly during E+2.
  - frame_err for a bad frame is high during E+1.
- Timeout frame_err is high for the one cycle after the counter reaches TIMEOUT.
- The PS/2 bit period (≥60 µs) far exceeds pipeline depth, so no back-pressure or byte buffering is required; at most one byte is in flight.
- key_press and frame_err are never high for more than one consecutive cycle.

## Test plan
- Frame 0x1C, parity bit 0, stop 1 -> scan_code=1C, key_down=1, key_press one pulse, press_count=01, frame_err never asserted.
- Then 1C,1C,1C (typematic), F0,1C -> no further key_press, press_count stays 01; after the break, key_down=0, scan_code=00.
- E0,75 then E0,F0,75 -> scan_code=75 with scan_ext=1, press_count+1; then scan_code=00, scan_ext=0, key_down=0.
- Frame 0x16 with parity bit 1 (wrong) -> frame_err one pulse, outputs unchanged, FSM IDLE; next valid 0x16 -> scan_code=16.
- 5 ps2_clk edges then idle > TIMEOUT cycles -> frame_err one pulse; next full frame 0x45 decodes to scan_code=45.
- 256 press/release pairs of 0x1C -> press_count wraps from FF to 00; assert clrn low after 6 bits of a frame -> all outputs 0 immediately, next frame decodes correctly.
